// File: rtl/stream_demux2.sv
// Single-input, two-output stream demultiplexer with a DEPTH-entry FIFO per output.
// in_sel steers each accepted word to out0 or out1, and a 16-bit counter per port tracks words delivered.
module stream_demux2 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [15:0]      out0_count,
    output logic [15:0]      out1_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] OCC_FULL = (PW + 1)'(DEPTH);

    logic [1:0]            full;
    logic [1:0]            empty;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            out_ready;
    logic [1:0][WIDTH-1:0] head;
    logic [1:0][15:0]      count;

    assign out_ready = {out1_ready, out0_ready};

    // Only the fullness of the currently selected FIFO gates the producer, so
    // a full FIFO never blocks traffic to the other port.
    assign in_ready = ~full[in_sel];

    for (genvar k = 0; k < 2; k++) begin : g_fifo
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]    rd_ptr;
        logic [PW-1:0]    wr_ptr;
        logic [PW:0]      occ;
        logic [15:0]      delivered;

        assign full[k]  = (occ == OCC_FULL);
        assign empty[k] = (occ == '0);
        assign push[k]  = in_valid && in_ready && (in_sel == 1'(k));
        assign pop[k]   = !empty[k] && out_ready[k];
        assign head[k]  = mem[rd_ptr];
        assign count[k] = delivered;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                occ       <= '0;
                delivered <= '0;
            end else begin
                if (push[k]) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop[k]) begin
                    rd_ptr    <= rd_ptr + PW'(1);
                    delivered <= delivered + 16'd1;
                end
                case ({push[k], pop[k]})
                    2'b10:   occ <= occ + (PW + 1)'(1);
                    2'b01:   occ <= occ - (PW + 1)'(1);
                    default: occ <= occ;
                endcase
            end
        end

        // Storage is left unreset; the head is only meaningful while valid is high.
        always_ff @(posedge clk) begin
            if (push[k]) begin
                mem[wr_ptr] <= in_data;
            end
        end
    end

    assign out0_valid = ~empty[0];
    assign out1_valid = ~empty[1];
    assign out0_data  = head[0];
    assign out1_data  = head[1];
    assign out0_count = count[0];
    assign out1_count = count[1];

endmodule

// File: tb/tb_stream_demux2.sv
// Directed bench for stream_demux2 (WIDTH=8, DEPTH=2): reset, routing, backpressure,
// full-with-pop, concurrency, pointer wrap, counter wrap and mid-stream async reset.
module tb_stream_demux2;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_sel;
    logic        out0_valid;
    logic        out0_ready;
    logic [7:0]  out0_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [7:0]  out1_data;
    logic [15:0] out0_count;
    logic [15:0] out1_count;

    int          total = 0;
    int          bad = 0;

    stream_demux2 #(.WIDTH(8), .DEPTH(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out0_count (out0_count),
        .out1_count (out1_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic s, input logic [7:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [7:0]  q[$];
        logic [15:0] exp_cnt1;
        int          sent;
        int          got_n;
        int          n;
        logic        do_pop;
        logic        do_push;

        reset_n    = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        apply_stimulus(1'b0, 1'b0, 8'h00);

        // Reset held across clock pulses
        tick();
        tick();
        check_output("rst_out0_valid", out0_valid, 0);
        check_output("rst_out1_valid", out1_valid, 0);
        check_output("rst_in_ready", in_ready, 1);
        check_output("rst_out0_count", out0_count, 0);
        check_output("rst_out1_count", out1_count, 0);
        reset_n = 1'b1;

        // Routing
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        apply_stimulus(1'b1, 1'b0, 8'hA5);
        tick();
        apply_stimulus(1'b1, 1'b1, 8'h3C);
        check_output("route_out0_valid", out0_valid, 1);
        check_output("route_out0_data", out0_data, 8'hA5);
        check_output("route_out1_idle", out1_valid, 0);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'h00);
        check_output("route_out0_popped", out0_valid, 0);
        check_output("route_out1_valid", out1_valid, 1);
        check_output("route_out1_data", out1_data, 8'h3C);
        check_output("route_out0_count", out0_count, 1);
        tick();
        check_output("route_out1_count", out1_count, 1);
        check_output("route_out1_popped", out1_valid, 0);

        // Backpressure on port 0 must not block port 1
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        apply_stimulus(1'b1, 1'b0, 8'h01);
        tick();
        apply_stimulus(1'b1, 1'b0, 8'h02);
        tick();
        apply_stimulus(1'b1, 1'b0, 8'h99);
        #1;
        check_output("bp_ready_sel0", in_ready, 0);
        apply_stimulus(1'b1, 1'b1, 8'h03);
        #1;
        check_output("bp_ready_sel1", in_ready, 1);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'h00);
        #1;
        check_output("bp_ready_sel0_still", in_ready, 0);
        check_output("bp_out1_valid", out1_valid, 1);
        check_output("bp_out1_data", out1_data, 8'h03);
        out0_ready = 1'b1;
        #1;
        check_output("bp_first", out0_data, 8'h01);
        tick();
        check_output("bp_second", out0_data, 8'h02);
        check_output("bp_count0_a", out0_count, 2);
        tick();
        check_output("bp_out0_empty", out0_valid, 0);
        check_output("bp_count0_b", out0_count, 3);
        out1_ready = 1'b1;
        tick();
        check_output("bp_count1", out1_count, 2);
        check_output("bp_out1_empty", out1_valid, 0);
        out1_ready = 1'b0;

        // Full FIFO refuses input even while popping
        out0_ready = 1'b0;
        apply_stimulus(1'b1, 1'b0, 8'h11);
        tick();
        apply_stimulus(1'b1, 1'b0, 8'h22);
        tick();
        out0_ready = 1'b1;
        apply_stimulus(1'b1, 1'b0, 8'h33);
        #1;
        check_output("fp_refuse", in_ready, 0);
        tick();
        check_output("fp_head_after_pop", out0_data, 8'h22);
        check_output("fp_ready_again", in_ready, 1);
        check_output("fp_count0_a", out0_count, 4);
        tick();
        check_output("fp_push_pop_valid", out0_valid, 1);
        check_output("fp_push_pop_data", out0_data, 8'h33);
        check_output("fp_count0_b", out0_count, 5);
        apply_stimulus(1'b0, 1'b0, 8'h00);
        tick();
        check_output("fp_drained", out0_valid, 0);
        check_output("fp_count0_c", out0_count, 6);

        // Port 0 pops while port 1 is fed every cycle
        out0_ready = 1'b0;
        apply_stimulus(1'b1, 1'b0, 8'hA0);
        tick();
        apply_stimulus(1'b1, 1'b0, 8'hA1);
        tick();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, 1'b1, 8'h40 + 8'(i));
            tick();
            check_output("cc_out1_valid", out1_valid, 1);
            check_output("cc_out1_data", out1_data, 8'h40 + 8'(i));
            check_output("cc_out0_valid", out0_valid, (i == 0));
            if (i == 0) check_output("cc_out0_data", out0_data, 8'hA1);
        end
        apply_stimulus(1'b0, 1'b0, 8'h00);
        tick();
        check_output("cc_count0", out0_count, 8);
        check_output("cc_count1", out1_count, 8);
        exp_cnt1 = 16'd8;

        // Ten words through port 1 under random backpressure
        sent  = 0;
        got_n = 0;
        for (int cyc = 0; cyc < 200 && got_n < 10; cyc++) begin
            out1_ready = 1'($urandom_range(0, 1));
            apply_stimulus(sent < 10, 1'b1, 8'h50 + 8'(sent));
            #1;
            check_output("wrap_ready", in_ready, q.size() < 2);
            check_output("wrap_valid", out1_valid, q.size() != 0);
            if (q.size() != 0) check_output("wrap_data", out1_data, q[0]);
            do_pop  = out1_ready && (q.size() != 0);
            do_push = (sent < 10) && (q.size() < 2);
            tick();
            if (do_pop) begin
                void'(q.pop_front());
                got_n++;
                exp_cnt1++;
            end
            if (do_push) begin
                q.push_back(8'h50 + 8'(sent));
                sent++;
            end
        end
        apply_stimulus(1'b0, 1'b0, 8'h00);
        check_output("wrap_delivered", got_n, 10);
        check_output("wrap_count1", out1_count, exp_cnt1);

        // Long stream drives out1_count up to and through 16'hFFFF
        out1_ready = 1'b1;
        n = 32'hFFFF - int'(exp_cnt1);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b1, 1'b1, 8'(i));
            tick();
        end
        apply_stimulus(1'b0, 1'b0, 8'h00);
        check_output("cw_count_fffe", out1_count, 16'hFFFE);
        tick();
        check_output("cw_count_ffff", out1_count, 16'hFFFF);
        apply_stimulus(1'b1, 1'b1, 8'h5A);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'h00);
        tick();
        check_output("cw_count_wrap", out1_count, 16'h0000);

        // Asynchronous reset with words buffered in both FIFOs
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        apply_stimulus(1'b1, 1'b0, 8'hB1);
        tick();
        apply_stimulus(1'b1, 1'b0, 8'hB2);
        tick();
        apply_stimulus(1'b1, 1'b1, 8'hB3);
        tick();
        apply_stimulus(1'b1, 1'b0, 8'hEE);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("ar_out0_valid", out0_valid, 0);
        check_output("ar_out1_valid", out1_valid, 0);
        check_output("ar_in_ready", in_ready, 1);
        check_output("ar_count0", out0_count, 0);
        check_output("ar_count1", out1_count, 0);
        tick();
        check_output("ar_held_out0_valid", out0_valid, 0);
        reset_n = 1'b1;
        apply_stimulus(1'b1, 1'b0, 8'h77);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'h00);
        check_output("ar_first_valid", out0_valid, 1);
        check_output("ar_first_data", out0_data, 8'h77);
        check_output("ar_out1_still_empty", out1_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_demux2.md
STREAM_DEMUX2 -- requirements
Module: stream_demux2

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 2, giving the entries per output FIFO; it SHALL be a power of two, at least 2.
REQ-003 The module SHALL have port clk  input  1  as its single clock; all state SHALL update on the rising edge.
REQ-004 The module SHALL have port reset_n  input  1  as the reset, asynchronous and active-low.
REQ-005 The module SHALL have port in_valid  input  1  as the producer data-valid.
REQ-006 The module SHALL have port in_ready  output  1  as the producer ready.
REQ-007 The module SHALL have port in_data  input  WIDTH  as the producer data.
REQ-008 The module SHALL have port in_sel  input  1  as the destination select: 0 routes to out0, 1 routes to out1.
REQ-009 The module SHALL have ports out0_valid  output  1, out0_ready  input  1, out0_data  output  WIDTH  as consumer port 0.
REQ-010 The module SHALL have ports out1_valid  output  1, out1_ready  input  1, out1_data  output  WIDTH  as consumer port 1.
REQ-011 The module SHALL have ports out0_count, out1_count  output  16  as the delivered-word counters, one per port.

Function
REQ-012 Each output k SHALL own an independent DEPTH-entry FIFO with read pointer, write pointer and occupancy count registers.
REQ-013 in_ready SHALL be combinational and SHALL equal NOT full of the FIFO selected by the current in_sel.
REQ-014 An input transfer SHALL occur on a rising edge when in_valid=1 and in_ready=1; in_data SHALL then be written to FIFO[in_sel].
REQ-015 in_data, in_sel and in_valid SHALL be ignored when no transfer occurs; the unselected FIFO SHALL never be written.
REQ-016 outk_valid SHALL be 1 exactly when FIFO k is non-empty, and outk_data SHALL show the head entry (registered storage, no combinational path from in_data).
REQ-017 An output transfer on port k SHALL occur on a rising edge when outk_valid=1 and outk_ready=1; the head SHALL be removed.
REQ-018 Latency: a word accepted at edge N SHALL be visible on outk_valid/outk_data after edge N, with no bypass.
REQ-019 Words to the same port SHALL be delivered in acceptance order; the two ports SHALL be mutually independent.
REQ-020 A full FIFO k SHALL refuse input (in_ready=0 when in_sel=k) even if port k pops in the same cycle.
REQ-021 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave its occupancy unchanged.
REQ-022 A pop on port k and a push to port 1-k in the same cycle SHALL both complete.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 outk_ready asserted while outk_valid=0 SHALL have no effect.
REQ-025 outk_count SHALL increment by 1 on each port-k output transfer and SHALL wrap from 16'hFFFF to 0.
REQ-026 A producer that keeps in_valid high with a changing in_sel SHALL be allowed; the handshake is evaluated each cycle against the current in_sel.

Reset
REQ-027 While reset_n=0, all pointers, occupancies and counters SHALL clear to 0 immediately, without waiting for clk.
REQ-028 While reset_n=0, out0_valid=0, out1_valid=0 and in_ready=1.
REQ-029 Reset asserted mid-operation SHALL discard all buffered words; no partial transfer SHALL complete on the edge coincident with reset.
REQ-030 The first transfer after reset_n deasserts SHALL be allowed on the first subsequent rising edge.
REQ-031 FIFO storage contents need no reset; outk_data SHALL be don't-care while outk_valid=0.

Verification
REQ-032 Reset stimulus: hold reset_n=0, pulse clk, check out0_valid=0, out1_valid=0, in_ready=1 and both counts=0; then assert reset_n=0 asynchronously between edges with data buffered and check valids drop at once.
REQ-033 Routing stimulus: push 8'hA5 with sel=0, then 8'h3C with sel=1, with both readys=1 -> out0 shows A5 and out1 shows 3C, each one cycle after its accept; then out0_count=1 and out1_count=1.
REQ-034 Backpressure stimulus: out0_ready=0, push 8'h01, 8'h02 (DEPTH=2), sel=0 -> in_ready=0 for sel=0 but 1 for sel=1; push 8'h03 with sel=1 succeeds; release out0_ready -> 01 then 02 delivered in order.
REQ-035 Full-with-pop stimulus: FIFO0 full, out0_ready=1, in_valid=1 with sel=0 -> no accept that cycle, one pop; accept on the next cycle.
REQ-036 Wrap stimulus: stream 10 words to port 1 with random out1_ready -> order preserved across pointer wrap; preload out1_count near 16'hFFFF via a long stream and confirm it wraps to 0.
REQ-037 Concurrency stimulus: push to port 1 while port 0 pops each cycle for 6 cycles -> no lost or duplicated words, counts match delivered words.
